// File: rtl/async_fifo_01_pkg.sv
// ---------------------------------------------------------------------------
// async_fifo_01_pkg
//   Shared types and helpers for the async_fifo_01 single-clock FIFO.
//   - occ_op_e : what happens to the occupancy counter in a given cycle.
//   - occ_op() : turns the two accepted-request strobes into an occ_op_e.
// ---------------------------------------------------------------------------
package async_fifo_01_pkg;

  typedef enum logic [1:0] {
    OCC_HOLD = 2'd0,  // neither request accepted, or both accepted
    OCC_INC  = 2'd1,  // write accepted on its own
    OCC_DEC  = 2'd2   // read accepted on its own
  } occ_op_e;

  function automatic occ_op_e occ_op(input logic wr_acc, input logic rd_acc);
    occ_op_e op;
    op = OCC_HOLD;
    if (wr_acc && !rd_acc) op = OCC_INC;
    if (rd_acc && !wr_acc) op = OCC_DEC;
    return op;
  endfunction

endpackage

// File: rtl/async_fifo_01_mem.sv
// ---------------------------------------------------------------------------
// async_fifo_01_mem
//   Simple dual-port RAM: one write port and one synchronous read port on
//   the same clock. The storage array is never cleared; only the read-data
//   register is reset.
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset (read register only)
//   i_wr_en    in   write strobe
//   i_wr_addr  in   write address
//   i_wr_data  in   write data
//   i_rd_en    in   read strobe; o_rd_data holds while low
//   i_rd_addr  in   read address
//   o_rd_data  out  registered read data
// ---------------------------------------------------------------------------
module async_fifo_01_mem #(
  parameter int data_width = 8,
  parameter int addr_width = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_wr_en,
  input  logic [addr_width-1:0] i_wr_addr,
  input  logic [data_width-1:0] i_wr_data,
  input  logic                  i_rd_en,
  input  logic [addr_width-1:0] i_rd_addr,
  output logic [data_width-1:0] o_rd_data
);

  logic [data_width-1:0] r_mem [2**addr_width];
  logic [data_width-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_data <= '0;
    end else if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/async_fifo_01.sv
// ---------------------------------------------------------------------------
// async_fifo_01
//   Single-clock FIFO with registered read data and almost-full /
//   almost-empty thresholds. All status flags decode the occupancy counter;
//   pointers are only used for addressing.
// Handshake: a write is taken on a rising edge when wr_en=1 and full=0; a
//   read is taken when rd_en=1 and empty=0. A refused request has no effect
//   and is not remembered. Read data appears on data_out one cycle after the
//   accepting edge and holds until the next accepted read.
// Ports:
//   clk           in   clock, rising edge
//   rst           in   synchronous active-high reset, wins over requests
//   wr_en         in   write request
//   data_in       in   write data
//   rd_en         in   read request
//   data_out      out  registered read data
//   full          out  occupancy == depth
//   empty         out  occupancy == 0
//   almost_full   out  occupancy >= almost_full_gap
//   almost_empty  out  occupancy <= almost_empty_gap
// ---------------------------------------------------------------------------
module async_fifo_01
  import async_fifo_01_pkg::*;
#(
  parameter int data_width       = 8,
  parameter int addr_width       = 6,
  parameter int depth            = 64,
  parameter int almost_full_gap  = 50,
  parameter int almost_empty_gap = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [data_width-1:0] data_in,
  input  logic                  rd_en,
  output logic [data_width-1:0] data_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty
);

  localparam int CW = addr_width + 1;
  localparam logic [CW-1:0]         DEPTH_C = CW'(depth);
  localparam logic [CW-1:0]         AF_C    = CW'(almost_full_gap);
  localparam logic [CW-1:0]         AE_C    = CW'(almost_empty_gap);
  localparam logic [CW-1:0]         CNT_ONE = CW'(1);
  localparam logic [addr_width-1:0] PTR_ONE = addr_width'(1);

  if (depth != 2 ** addr_width) begin : g_bad_depth
    $error("async_fifo_01: depth must equal 2**addr_width");
  end

  logic [addr_width-1:0] r_wr_ptr;
  logic [addr_width-1:0] r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic                  w_wr_acc;
  logic                  w_rd_acc;
  occ_op_e               w_occ_op;

  // A write while full is refused even if a read frees a slot in the same
  // cycle; the read itself still proceeds.
  assign w_wr_acc = wr_en && !full;
  assign w_rd_acc = rd_en && !empty;
  assign w_occ_op = occ_op(w_wr_acc, w_rd_acc);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case (w_occ_op)
        OCC_INC: r_count <= r_count + CNT_ONE;
        OCC_DEC: r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  assign full         = (r_count == DEPTH_C);
  assign empty        = (r_count == '0);
  assign almost_full  = (r_count >= AF_C);
  assign almost_empty = (r_count <= AE_C);

  // A simultaneous read uses the old rd_ptr; it can never hit the slot being
  // written because a read requires at least one stored word.
  async_fifo_01_mem #(
    .data_width (data_width),
    .addr_width (addr_width)
  ) u_mem (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (w_wr_acc),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (data_in),
    .i_rd_en   (w_rd_acc),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (data_out)
  );

endmodule

// File: tb/tb_async_fifo_01.sv
// ---------------------------------------------------------------------------
// tb_async_fifo_01
//   Bench for async_fifo_01. A queue-based model follows the DUT on every
//   rising edge and a compare process checks all outputs on every falling
//   edge; directed phases add literal expectations at the interesting points.
// ---------------------------------------------------------------------------
module tb_async_fifo_01;

  localparam int DW    = 8;
  localparam int DEPTH = 64;
  localparam int AFG   = 50;
  localparam int AEG   = 10;

  logic          clk;
  logic          rst;
  logic          wr_en;
  logic [DW-1:0] data_in;
  logic          rd_en;
  logic [DW-1:0] data_out;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;

  int n_checks;
  int n_fail;
  bit cmp_en;

  // -------------------------------------------------------------------------
  // Clock / reset
  // -------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  async_fifo_01 #(
    .data_width       (DW),
    .addr_width       (6),
    .depth            (DEPTH),
    .almost_full_gap  (AFG),
    .almost_empty_gap (AEG)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .data_in      (data_in),
    .rd_en        (rd_en),
    .data_out     (data_out),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
  );

  // -------------------------------------------------------------------------
  // Behavioural model: a queue of stored words plus the last word read.
  // -------------------------------------------------------------------------
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] m_dout;

  always @(posedge clk) begin
    bit wa;
    bit ra;
    if (rst) begin
      exp_q.delete();
      m_dout = '0;
    end else begin
      wa = wr_en && (exp_q.size() < DEPTH);
      ra = rd_en && (exp_q.size() > 0);
      if (ra) m_dout = exp_q.pop_front();
      if (wa) exp_q.push_back(data_in);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // -------------------------------------------------------------------------
  // Scoreboard compare: every falling edge once the model is defined.
  // -------------------------------------------------------------------------
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cmp_data_out",     32'(data_out),     32'(m_dout));
      chk("cmp_full",         32'(full),         32'(exp_q.size() == DEPTH));
      chk("cmp_empty",        32'(empty),        32'(exp_q.size() == 0));
      chk("cmp_almost_full",  32'(almost_full),  32'(exp_q.size() >= AFG));
      chk("cmp_almost_empty", 32'(almost_empty), 32'(exp_q.size() <= AEG));
    end
  end

  // -------------------------------------------------------------------------
  // Driver tasks: inputs change on the falling edge, are taken at the next
  // rising edge, and the task returns on the following falling edge.
  // -------------------------------------------------------------------------
  task automatic step(input bit we, input logic [DW-1:0] d, input bit re);
    wr_en   = we;
    data_in = d;
    rd_en   = re;
    @(negedge clk);
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    for (int i = 0; i < cycles; i++) step(1'b1, 8'hA5, 1'b1);
    rst = 1'b0;
  endtask

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  logic [DW-1:0] fill_tbl [6];
  logic [DW-1:0] last_w;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    cmp_en   = 1'b0;
    rst      = 1'b1;
    wr_en    = 1'b0;
    rd_en    = 1'b0;
    data_in  = '0;
    fill_tbl = '{8'hFF, 8'h9B, 8'h2B, 8'h90, 8'h0B, 8'h9D};

    // Reset held two cycles with both requests high.
    do_reset(2);
    chk("rst_data_out",     32'(data_out),     32'h0);
    chk("rst_empty",        32'(empty),        32'h1);
    chk("rst_almost_empty", 32'(almost_empty), 32'h1);
    chk("rst_full",         32'(full),         32'h0);
    chk("rst_almost_full",  32'(almost_full),  32'h0);
    cmp_en = 1'b1;

    // Fill to 64 with thresholds pinned at their boundaries.
    for (int i = 1; i <= DEPTH; i++) begin
      last_w = (i <= 6) ? fill_tbl[i-1] : DW'(i * 7 + 3);
      step(1'b1, last_w, 1'b0);
      if (i == 1)  chk("fill_empty_1",  32'(empty),        32'h0);
      if (i == 10) chk("fill_ae_10",    32'(almost_empty), 32'h1);
      if (i == 11) chk("fill_ae_11",    32'(almost_empty), 32'h0);
      if (i == 49) chk("fill_af_49",    32'(almost_full),  32'h0);
      if (i == 50) chk("fill_af_50",    32'(almost_full),  32'h1);
      if (i == 63) chk("fill_full_63",  32'(full),         32'h0);
      if (i == 64) chk("fill_full_64",  32'(full),         32'h1);
    end
    step(1'b1, 8'hEE, 1'b0);  // dropped
    chk("drop_full",   32'(full),  32'h1);
    chk("drop_depth",  32'(exp_q.size()), 32'd64);

    // Drain in write order.
    step(1'b0, '0, 1'b1);
    chk("drain_first", 32'(data_out), 32'hFF);
    step(1'b0, '0, 1'b1);
    chk("drain_second", 32'(data_out), 32'h9B);
    for (int i = 2; i < DEPTH; i++) step(1'b0, '0, 1'b1);
    chk("drain_empty", 32'(empty), 32'h1);
    chk("drain_last",  32'(data_out), 32'(last_w));
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    chk("drain_hold",  32'(data_out), 32'(last_w));

    // Simultaneous read/write at count 20.
    for (int i = 0; i < 20; i++) step(1'b1, DW'($urandom_range(0, 255)), 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, DW'($urandom_range(0, 255)), 1'b1);
      chk("simul_ae", 32'(almost_empty), 32'h0);
      chk("simul_af", 32'(almost_full),  32'h0);
    end
    chk("simul_depth", 32'(exp_q.size()), 32'd20);
    for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b1);

    // Wrap: 100 write/read pairs at low occupancy with distinct data.
    step(1'b1, 8'h00, 1'b0);
    for (int i = 1; i <= 100; i++) begin
      step(1'b1, DW'(i), 1'b0);
      step(1'b0, '0, 1'b1);
      if (i == 100) chk("wrap_last", 32'(data_out), 32'd99);
    end
    for (int i = 0; i < 2; i++) step(1'b0, '0, 1'b1);
    chk("wrap_final", 32'(data_out), 32'd100);

    // Random traffic with shifting read/write bias. A write and a read are
    // never both requested while full.
    for (int ph = 0; ph < 4; ph++) begin
      for (int i = 0; i < 150; i++) begin
        bit we;
        bit re;
        we = ($urandom_range(0, 99) < (ph[0] ? 70 : 35));
        re = ($urandom_range(0, 99) < (ph[0] ? 35 : 70));
        if (exp_q.size() == DEPTH && we && re) we = 1'b0;
        step(we, DW'($urandom()), re);
      end
    end

    // Mid-run reset at count 30.
    do_reset(1);
    for (int i = 0; i < 30; i++) step(1'b1, DW'($urandom()), 1'b0);
    chk("mid_ae_30", 32'(almost_empty), 32'h0);
    do_reset(1);
    chk("mid_empty", 32'(empty),    32'h1);
    chk("mid_dout",  32'(data_out), 32'h0);
    step(1'b1, 8'h5A, 1'b0);
    step(1'b0, '0, 1'b1);
    chk("mid_5a",    32'(data_out), 32'h5A);
    chk("mid_empty2", 32'(empty),   32'h1);

    step(1'b0, '0, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/async_fifo_01.md
# async_fifo_01

Single-clock, synchronous first-in/first-out buffer with registered read data and programmable almost-full/almost-empty thresholds. It decouples a producer and a consumer that share one clock domain but run at different average rates. Storage is a power-of-two RAM indexed by wrapping read/write pointers, with an occupancy counter that drives all status flags.

## Interface
Parameters:
- data_width, 8: word width in bits.
- addr_width, 6: pointer width; depth must equal 2**addr_width.
- depth, 64: number of storage words.
- almost_full_gap, 50: occupancy at or above which almost_full asserts.
- almost_empty_gap, 10: occupancy at or below which almost_empty asserts.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  write request.
- data_in  in  data_width  write data.
- rd_en  in  1  read request.
- data_out  out  data_width  registered read data.
- full  out  1  occupancy == depth.
- empty  out  1  occupancy == 0.
- almost_full  out  1  occupancy >= almost_full_gap.
- almost_empty  out  1  occupancy <= almost_empty_gap.

## Operation
- State: mem[depth], wr_ptr and rd_ptr (addr_width bits, wrap modulo depth), count (addr_width+1 bits, range 0..depth), and data_out register.
- Write is accepted when wr_en && !full: mem[wr_ptr] <= data_in, and wr_ptr increments.
- Read is accepted when rd_en && !empty: data_out <= mem[rd_ptr], and rd_ptr increments.
- count update: +1 on write only, -1 on read only, unchanged when both or neither are accepted.
- Write while full is dropped silently; nothing changes, even if rd_en is high that cycle. Read while empty is ignored, and data_out holds its value.
- When both requests are accepted in the same cycle, read data comes from the old rd_ptr. Write-then-read ordering on the same address cannot occur because count > 0 is required for the read.
- Flags are combinational decodes of count. No other outputs exist.
- Reset: wr_ptr=0, rd_ptr=0, count=0, data_out=0. Hence empty=1, almost_empty=1, full=0, almost_full=0. Memory contents are not cleared. Reset has priority over wr_en/rd_en and discards all stored data.

## Timing
- Write-to-flag latency: flags reflect an accepted write after the same rising edge (1 cycle).
- Read latency: data_out is valid 1 cycle after the rd_en edge and holds until the next accepted read.
- The first word written into an empty FIFO is readable on the following cycle: empty deasserts after the write edge.
- Wrap-around: the pointers roll from depth-1 to 0 with no gap. full is driven by count, never by pointer comparison.
- Reset mid-operation: on the next edge, state equals the power-up state regardless of pending requests.

## Structure
- Shared package: none required. Parameters stay module-local; the depth == 2**addr_width check is an elaboration-time assertion.
- Optional sub-module: fifo_mem_sp, a simple dual-port RAM (one write port, one synchronous read port, same clk). Pointer, count and flag logic stays in the top module.

## Test plan
- Reset: hold rst=1 for 2 cycles with wr_en=rd_en=1 -> data_out=0, empty=1, almost_empty=1, full=0, almost_full=0.
- Fill: write 0xFF, 0x9B, 0x2B, 0x90, 0x0B, 0x9D, then continuous writes to 64 total, with rd_en=0.
  - almost_empty=1 through count 10, 0 at 11.
  - almost_full=1 from count 50.
  - full=1 at 64.
  - A 65th write is dropped and count stays 64.
- Drain: rd_en=1, wr_en=0 from full -> data_out returns words in write order (0xFF first, 1 cycle after first rd_en edge). empty=1 after 64 reads. Further reads leave data_out at the last word.
- Simultaneous: at count 20, assert wr_en and rd_en for 10 cycles -> count stays 20, flags are stable, and output order is preserved.
- Wrap: perform 100 write/read pairs with distinct data through count 1..3 -> pointers wrap past 63 and every word reads back intact.
- Mid-run reset: at count 30, pulse rst for 1 cycle -> empty=1 next cycle. A subsequent write of 0x5A then a read returns 0x5A.
